load_store_agu: RTL and testbench
=================================

Name: load_store_agu

Overview:
Address-generation and alignment stage directly upstream of data_mem.
- Accepts a decoded load/store from the load/store reservation station and computes the effective address (EA).
- Builds the left-aligned byte-enable masks and store data that data_mem expects.
- For update forms, also emits EA as a register-write result for rA. This path has its own handshake, independent of the memory path.

Parameters:
RS_ID_WIDTH, 7, width of reservation-station tag carried with each op

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
input_valid  input  1  op offered
input_ready  output  1  op accepted when input_valid & input_ready
rs_id_in  input  RS_ID_WIDTH  tag of op
result_reg_addr_in  input  5  rD for loads (don't-care for stores)
ra_addr_in  input  5  rA, destination of the update result
ls_op_in  input  ls_op_t  size, is_store, byte_reverse, update
ra_is_zero  input  1  rA field is 0 (base treated as 0)
operand_a  input  32  rA value
operand_b  input  32  rB value or sign-extended D
store_data  input  32  rS value
mem_valid  output  1  to data_mem input_valid
mem_ready  input  1  from data_mem input_ready
rs_id_out  output  RS_ID_WIDTH  to data_mem
result_reg_addr_out  output  5  to data_mem
mem_address  output  32  EA
mem_write_en  output  4  byte enables, left-aligned
mem_write_data  output  32  store data, left-aligned
mem_read_en  output  4  byte enables, left-aligned
upd_valid  output  1  update result valid
upd_ready  input  1  update result consumed
upd_rs_id  output  RS_ID_WIDTH  tag of op
upd_reg_addr  output  5  rA
upd_value  output  32  EA

Behaviour:
- Bit numbering is [0:N-1], bit 0 = MSB.
- EA = (ra_is_zero ? 0 : operand_a) + operand_b, modulo 2^32. No overflow or alignment fault; misalignment is handled by data_mem.
- Byte enables by size:
  - BYTE = 1000
  - HALF = 1100
  - WORD = 1111
- Only one enable set is active per op:
  - store: mem_write_en = size pattern, mem_read_en = 0000
  - load: mem_read_en = size pattern, mem_write_en = 0000
- Store data, left-aligned:
  - BYTE = {rS[24:31], 24'b0}
  - HALF = {rS[16:31], 16'b0}
  - WORD = rS
  - byte_reverse HALF = {rS[24:31], rS[16:23], 16'b0}
  - byte_reverse WORD = {rS[24:31], rS[16:23], rS[8:15], rS[0:7]}
  - byte_reverse BYTE behaves as plain BYTE.
  - For loads, mem_write_data = 0.
- Single output register stage. Fields captured on accept: mem_* fields, tags, upd_* fields, plus two pending bits, mem_pend and upd_pend.
- On accept: mem_pend = 1; upd_pend = ls_op_in.update.
- Outputs: mem_valid = mem_pend; upd_valid = upd_pend.
- Pending bits clear independently:
  - mem_pend clears on mem_valid & mem_ready.
  - upd_pend clears on upd_valid & upd_ready.
- Stage is free when neither bit is set after this cycle's handshakes.
- input_ready = ~mem_pend_next_free_condition, i.e. input_ready = (~mem_pend | mem_ready) & (~upd_pend | upd_ready). This is combinational from the ready inputs.
- Latency: accept at edge N gives mem_valid high from N+1. Throughput is 1 op/cycle when both consumers are ready.
- Simultaneous accept and completion in the same cycle: the new op overwrites the register, with pending bits set from the new op.
- Output fields hold stable while the corresponding valid is high and not yet handshaken.
- update with ra_is_zero (invalid ISA form): processed as normal, upd_value = operand_b.
- Reset (rst_n low, any time, including mid-handshake):
  - mem_pend = upd_pend = 0, so mem_valid = upd_valid = 0.
  - All data outputs = 0.
  - input_ready reads 1 once rst_n is high; an op in flight is dropped.

Decomposition:
- ppc_types gains:
  - ls_size_t enum {LS_BYTE, LS_HALF, LS_WORD}
  - ls_op_t packed struct {ls_size_t size; logic is_store; logic byte_reverse; logic update}
  - functions ls_byte_mask(ls_size_t) and ls_align_store(ls_size_t, logic byte_reverse, logic[0:31] data)
- No sub-module: the fork and register stage is a single always_ff plus combinational next-state.

Test Plan:
- Reset: hold rst_n low 3 cycles with input_valid = 1 -> mem_valid = upd_valid = 0, all outputs 0. After release, input_ready = 1.
- stw, operand_a = 0x1000, operand_b = 0x0003, rS = 0xA1B2C3D4, no update -> next cycle:
  - mem_address = 0x00001003
  - mem_write_en = 1111
  - mem_write_data = 0xA1B2C3D4
  - mem_read_en = 0000
  - upd_valid = 0
- sthbrx, rS = 0x00001234 -> mem_write_en = 1100, mem_write_data = 0x34120000. Also lbz with ra_is_zero = 1, operand_a = 0xFFFF, operand_b = 0x20 -> mem_address = 0x20, mem_read_en = 1000.
- lwzu, operand_a = 0xFFFFFFFC, operand_b = 8 -> mem_address = 0x00000004 (wrap), upd_value = 0x00000004, upd_reg_addr = ra_addr_in.
- Fork: lwzu with upd_ready = 0 and mem_ready = 1 for 4 cycles:
  - mem handshake occurs once, then mem_valid drops.
  - upd_valid stays high with stable data.
  - input_ready = 0 until upd_ready = 1, then the next op is accepted in that same cycle.
- Back-to-back: 8 consecutive stores with mem_ready toggling 1,0,1,0… -> exactly 8 mem handshakes, in order, no duplicates or drops, and rs_id_out sequence matches the input order.

Source files
------------

// File: rtl/load_store_agu_pkg.sv
// Shared types and helpers for the load/store address-generation stage.
// Byte lanes and data words use MSB-first [0:N-1] numbering.
package load_store_agu_pkg;

  typedef enum logic [1:0] {
    LS_BYTE = 2'd0,
    LS_HALF = 2'd1,
    LS_WORD = 2'd2
  } ls_size_t;

  typedef struct packed {
    ls_size_t size;
    logic     is_store;
    logic     byte_reverse;
    logic     update;
  } ls_op_t;

  localparam logic [0:3] MASK_BYTE = 4'b1000;
  localparam logic [0:3] MASK_HALF = 4'b1100;
  localparam logic [0:3] MASK_WORD = 4'b1111;

  function automatic logic [0:3] ls_byte_mask(
    input ls_size_t size
  );
    logic [0:3] m;
    m = '0;
    unique case (1'b1)
      size == LS_BYTE: m = MASK_BYTE;
      size == LS_HALF: m = MASK_HALF;
      size == LS_WORD: m = MASK_WORD;
      default:         m = '0;
    endcase
    return m;
  endfunction

  // Low-order source bytes move to the left-most lanes.
  function automatic logic [0:31] ls_align_store(
    input ls_size_t    size,
    input logic        byte_reverse,
    input logic [0:31] data
  );
    logic [0:31] d;
    d = '0;
    unique case (1'b1)
      size == LS_BYTE:
        d = {data[24:31], 24'b0};
      size == LS_HALF:
        d = byte_reverse
          ? {data[24:31], data[16:23], 16'b0}
          : {data[16:31], 16'b0};
      size == LS_WORD:
        d = byte_reverse
          ? {data[24:31], data[16:23],
             data[8:15], data[0:7]}
          : data;
      default:
        d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_store_agu_if.sv
// Bundle of the op input, data_mem output and update-result ports.
// master drives ops and consumes results; slave is the AGU.
interface load_store_agu_if
  import load_store_agu_pkg::*;
#(
  parameter int RS_ID_WIDTH = 7
);

  logic                   input_valid;
  logic                   input_ready;
  logic [RS_ID_WIDTH-1:0] rs_id_in;
  logic [4:0]             result_reg_addr_in;
  logic [4:0]             ra_addr_in;
  ls_op_t                 ls_op_in;
  logic                   ra_is_zero;
  logic [0:31]            operand_a;
  logic [0:31]            operand_b;
  logic [0:31]            store_data;

  logic                   mem_valid;
  logic                   mem_ready;
  logic [RS_ID_WIDTH-1:0] rs_id_out;
  logic [4:0]             result_reg_addr_out;
  logic [0:31]            mem_address;
  logic [0:3]             mem_write_en;
  logic [0:31]            mem_write_data;
  logic [0:3]             mem_read_en;

  logic                   upd_valid;
  logic                   upd_ready;
  logic [RS_ID_WIDTH-1:0] upd_rs_id;
  logic [4:0]             upd_reg_addr;
  logic [0:31]            upd_value;

  modport slave (
    input  input_valid,
    output input_ready,
    input  rs_id_in,
    input  result_reg_addr_in,
    input  ra_addr_in,
    input  ls_op_in,
    input  ra_is_zero,
    input  operand_a,
    input  operand_b,
    input  store_data,
    output mem_valid,
    input  mem_ready,
    output rs_id_out,
    output result_reg_addr_out,
    output mem_address,
    output mem_write_en,
    output mem_write_data,
    output mem_read_en,
    output upd_valid,
    input  upd_ready,
    output upd_rs_id,
    output upd_reg_addr,
    output upd_value
  );

  modport master (
    output input_valid,
    input  input_ready,
    output rs_id_in,
    output result_reg_addr_in,
    output ra_addr_in,
    output ls_op_in,
    output ra_is_zero,
    output operand_a,
    output operand_b,
    output store_data,
    input  mem_valid,
    output mem_ready,
    input  rs_id_out,
    input  result_reg_addr_out,
    input  mem_address,
    input  mem_write_en,
    input  mem_write_data,
    input  mem_read_en,
    input  upd_valid,
    output upd_ready,
    input  upd_rs_id,
    input  upd_reg_addr,
    input  upd_value
  );

endinterface

// File: rtl/load_store_agu.sv
// Load/store AGU: effective address, lane masks and store alignment,
// registered once and forked to data_mem and the rA update port.
module load_store_agu
  import load_store_agu_pkg::*;
#(
  parameter int RS_ID_WIDTH = 7
) (
  input logic             clk,
  input logic             rst_n,
  load_store_agu_if.slave bus
);

  logic                   accept;
  logic                   mem_pend;
  logic                   mem_pend_d;
  logic                   upd_pend;
  logic                   upd_pend_d;

  logic [0:31]            base;
  logic [0:31]            ea;
  logic [0:3]             mask;
  logic [0:3]             wen_d;
  logic [0:3]             ren_d;
  logic [0:31]            wdata_d;

  logic [RS_ID_WIDTH-1:0] rs_id_q;
  logic [4:0]             rd_q;
  logic [4:0]             ra_q;
  logic [0:31]            ea_q;
  logic [0:3]             wen_q;
  logic [0:3]             ren_q;
  logic [0:31]            wdata_q;

  // Stage frees up once both consumers finish this cycle.
  assign bus.input_ready =
    (~mem_pend | bus.mem_ready) &
    (~upd_pend | bus.upd_ready);

  assign accept = bus.input_valid
                & bus.input_ready;

  always_comb begin
    base    = bus.ra_is_zero ? '0 : bus.operand_a;
    ea      = base + bus.operand_b;
    mask    = ls_byte_mask(bus.ls_op_in.size);
    wen_d   = '0;
    ren_d   = '0;
    wdata_d = '0;
    if (bus.ls_op_in.is_store) begin
      wen_d   = mask;
      wdata_d = ls_align_store(
        bus.ls_op_in.size,
        bus.ls_op_in.byte_reverse,
        bus.store_data
      );
    end else begin
      ren_d = mask;
    end
  end

  always_comb begin
    mem_pend_d = mem_pend & ~bus.mem_ready;
    upd_pend_d = upd_pend & ~bus.upd_ready;
    if (accept) begin
      mem_pend_d = 1'b1;
      upd_pend_d = bus.ls_op_in.update;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_pend <= 1'b0;
      upd_pend <= 1'b0;
      rs_id_q  <= '0;
      rd_q     <= '0;
      ra_q     <= '0;
      ea_q     <= '0;
      wen_q    <= '0;
      ren_q    <= '0;
      wdata_q  <= '0;
    end else begin
      mem_pend <= mem_pend_d;
      upd_pend <= upd_pend_d;
      if (accept) begin
        rs_id_q <= bus.rs_id_in;
        rd_q    <= bus.result_reg_addr_in;
        ra_q    <= bus.ra_addr_in;
        ea_q    <= ea;
        wen_q   <= wen_d;
        ren_q   <= ren_d;
        wdata_q <= wdata_d;
      end
    end
  end

  assign bus.mem_valid           = mem_pend;
  assign bus.rs_id_out           = rs_id_q;
  assign bus.result_reg_addr_out = rd_q;
  assign bus.mem_address         = ea_q;
  assign bus.mem_write_en        = wen_q;
  assign bus.mem_write_data      = wdata_q;
  assign bus.mem_read_en         = ren_q;

  assign bus.upd_valid    = upd_pend;
  assign bus.upd_rs_id    = rs_id_q;
  assign bus.upd_reg_addr = ra_q;
  assign bus.upd_value    = ea_q;

endmodule

// File: tb/tb_load_store_agu.sv
// Directed bench for load_store_agu with a queue scoreboard
// on both the data_mem and update result ports.
module tb_load_store_agu;
  import load_store_agu_pkg::*;

  typedef struct {
    logic [6:0]  rs;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic [3:0]  ren;
  } mem_t;

  typedef struct {
    logic [6:0]  rs;
    logic [4:0]  ra;
    logic [31:0] value;
  } upd_t;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;
  int mem_hs = 0;
  int hs0;

  mem_t mem_q[$];
  upd_t upd_q[$];
  mem_t me;
  upd_t ue;

  load_store_agu_if #(.RS_ID_WIDTH(7)) ifc ();

  load_store_agu #(.RS_ID_WIDTH(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic mem_t model(
    input int          id,
    input logic [4:0]  rd,
    input ls_size_t    sz,
    input bit          st,
    input bit          br,
    input bit          raz,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] s
  );
    mem_t r;
    logic [3:0]  m;
    logic [31:0] d;
    case (sz)
      LS_BYTE: m = 4'b1000;
      LS_HALF: m = 4'b1100;
      default: m = 4'b1111;
    endcase
    case (sz)
      LS_BYTE: d = {s[7:0], 24'h0};
      LS_HALF: d = br ? {s[7:0], s[15:8], 16'h0}
                      : {s[15:0], 16'h0};
      default: d = br ? {s[7:0], s[15:8], s[23:16], s[31:24]}
                      : s;
    endcase
    r.rs    = id[6:0];
    r.rd    = rd;
    r.addr  = (raz ? 32'h0 : a) + b;
    r.wen   = st ? m : 4'h0;
    r.wdata = st ? d : 32'h0;
    r.ren   = st ? 4'h0 : m;
    return r;
  endfunction

  task automatic set_op(
    input int          id,
    input logic [4:0]  rd,
    input logic [4:0]  ra,
    input ls_size_t    sz,
    input bit          st,
    input bit          br,
    input bit          up,
    input bit          raz,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] s
  );
    ifc.rs_id_in                = id[6:0];
    ifc.result_reg_addr_in      = rd;
    ifc.ra_addr_in              = ra;
    ifc.ls_op_in.size           = sz;
    ifc.ls_op_in.is_store       = st;
    ifc.ls_op_in.byte_reverse   = br;
    ifc.ls_op_in.update         = up;
    ifc.ra_is_zero              = raz;
    ifc.operand_a               = a;
    ifc.operand_b               = b;
    ifc.store_data              = s;
    ifc.input_valid             = 1'b1;
  endtask

  task automatic wait_accept(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = ifc.input_ready;
      @(posedge clk);
      #1;
    end
    check(tag, {31'b0, ok}, 32'd1);
    ifc.input_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && ifc.mem_valid && ifc.mem_ready) begin
      mem_hs++;
      if (mem_q.size() == 0) begin
        check("mem_spurious", mem_q.size(), 32'd1);
      end else begin
        me = mem_q.pop_front();
        check("mem_rs_id", ifc.rs_id_out, me.rs);
        check("mem_rd", ifc.result_reg_addr_out, me.rd);
        check("mem_addr", ifc.mem_address, me.addr);
        check("mem_wen", ifc.mem_write_en, me.wen);
        check("mem_wdata", ifc.mem_write_data, me.wdata);
        check("mem_ren", ifc.mem_read_en, me.ren);
      end
    end
    if (rst_n && ifc.upd_valid && ifc.upd_ready) begin
      if (upd_q.size() == 0) begin
        check("upd_spurious", upd_q.size(), 32'd1);
      end else begin
        ue = upd_q.pop_front();
        check("upd_rs_id", ifc.upd_rs_id, ue.rs);
        check("upd_reg", ifc.upd_reg_addr, ue.ra);
        check("upd_value", ifc.upd_value, ue.value);
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    ifc.mem_ready = 1'b1;
    ifc.upd_ready = 1'b1;
    set_op(9, 5'd1, 5'd2, LS_WORD, 1'b1, 1'b0, 1'b1,
           1'b0, 32'h55, 32'h66, 32'h77);

    // reset held with an op offered
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_valid", ifc.mem_valid, 32'd0);
    check("rst_upd_valid", ifc.upd_valid, 32'd0);
    check("rst_addr", ifc.mem_address, 32'd0);
    check("rst_wen", ifc.mem_write_en, 32'd0);
    check("rst_wdata", ifc.mem_write_data, 32'd0);
    check("rst_ren", ifc.mem_read_en, 32'd0);
    check("rst_rs_id", ifc.rs_id_out, 32'd0);
    check("rst_upd_reg", ifc.upd_reg_addr, 32'd0);
    rst_n           = 1'b1;
    ifc.input_valid = 1'b0;
    ifc.mem_ready   = 1'b0;
    ifc.upd_ready   = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", ifc.input_ready, 32'd1);
    @(posedge clk);
    #1;
    ifc.mem_ready = 1'b1;
    ifc.upd_ready = 1'b1;

    // stw
    mem_q.push_back('{7'd1, 5'd3, 32'h0000_1003,
                      4'hF, 32'hA1B2_C3D4, 4'h0});
    set_op(1, 5'd3, 5'd4, LS_WORD, 1'b1, 1'b0, 1'b0,
           1'b0, 32'h1000, 32'h3, 32'hA1B2_C3D4);
    wait_accept("acc_stw");
    @(negedge clk);
    check("stw_latency", ifc.mem_valid, 32'd1);
    check("stw_no_upd", ifc.upd_valid, 32'd0);
    @(posedge clk);
    #1;

    // sthbrx
    mem_q.push_back('{7'd2, 5'd0, 32'h0000_0100,
                      4'hC, 32'h3412_0000, 4'h0});
    set_op(2, 5'd0, 5'd1, LS_HALF, 1'b1, 1'b1, 1'b0,
           1'b0, 32'h0, 32'h100, 32'h0000_1234);
    wait_accept("acc_sthbrx");

    // lbz with rA = 0
    mem_q.push_back('{7'd3, 5'd7, 32'h0000_0020,
                      4'h0, 32'h0, 4'h8});
    set_op(3, 5'd7, 5'd0, LS_BYTE, 1'b0, 1'b0, 1'b0,
           1'b1, 32'hFFFF, 32'h20, 32'hDEAD_BEEF);
    wait_accept("acc_lbz");

    // lwzu wrapping
    mem_q.push_back('{7'd4, 5'd9, 32'h0000_0004,
                      4'h0, 32'h0, 4'hF});
    upd_q.push_back('{7'd4, 5'd5, 32'h0000_0004});
    set_op(4, 5'd9, 5'd5, LS_WORD, 1'b0, 1'b0, 1'b1,
           1'b0, 32'hFFFF_FFFC, 32'h8, 32'h0);
    wait_accept("acc_lwzu");

    // update form with rA = 0
    mem_q.push_back('{7'd5, 5'd2, 32'h0000_0040,
                      4'h0, 32'h0, 4'h8});
    upd_q.push_back('{7'd5, 5'd0, 32'h0000_0040});
    set_op(5, 5'd2, 5'd0, LS_BYTE, 1'b0, 1'b0, 1'b1,
           1'b1, 32'h1234, 32'h40, 32'h0);
    wait_accept("acc_upd_raz");

    // store alignment variants
    mem_q.push_back('{7'd6, 5'd0, 32'h0000_0200,
                      4'h8, 32'hD400_0000, 4'h0});
    set_op(6, 5'd0, 5'd1, LS_BYTE, 1'b1, 1'b0, 1'b0,
           1'b0, 32'h100, 32'h100, 32'hA1B2_C3D4);
    wait_accept("acc_stb");
    mem_q.push_back('{7'd7, 5'd0, 32'h0000_0300,
                      4'hF, 32'hD4C3_B2A1, 4'h0});
    set_op(7, 5'd0, 5'd1, LS_WORD, 1'b1, 1'b1, 1'b0,
           1'b0, 32'h200, 32'h100, 32'hA1B2_C3D4);
    wait_accept("acc_stwbrx");
    mem_q.push_back('{7'd8, 5'd0, 32'h0000_0400,
                      4'h8, 32'hD400_0000, 4'h0});
    set_op(8, 5'd0, 5'd1, LS_BYTE, 1'b1, 1'b1, 1'b0,
           1'b0, 32'h300, 32'h100, 32'hA1B2_C3D4);
    wait_accept("acc_stb_br");
    mem_q.push_back('{7'd9, 5'd0, 32'h0000_0500,
                      4'hC, 32'hC3D4_0000, 4'h0});
    set_op(9, 5'd0, 5'd1, LS_HALF, 1'b1, 1'b0, 1'b0,
           1'b0, 32'h400, 32'h100, 32'hA1B2_C3D4);
    wait_accept("acc_sth");

    // fork: update consumer stalls
    ifc.upd_ready = 1'b0;
    mem_q.push_back('{7'd20, 5'd2, 32'h0000_2010,
                      4'h0, 32'h0, 4'hF});
    upd_q.push_back('{7'd20, 5'd6, 32'h0000_2010});
    set_op(20, 5'd2, 5'd6, LS_WORD, 1'b0, 1'b0, 1'b1,
           1'b0, 32'h2000, 32'h10, 32'h0);
    wait_accept("acc_fork");
    hs0 = mem_hs;
    mem_q.push_back('{7'd21, 5'd8, 32'h0000_3001,
                      4'h0, 32'h0, 4'h8});
    set_op(21, 5'd8, 5'd1, LS_BYTE, 1'b0, 1'b0, 1'b0,
           1'b0, 32'h3000, 32'h1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fork_in_ready", ifc.input_ready, 32'd0);
      check("fork_upd_valid", ifc.upd_valid, 32'd1);
      check("fork_upd_value", ifc.upd_value, 32'h2010);
      check("fork_upd_reg", ifc.upd_reg_addr, 32'd6);
      if (i > 0)
        check("fork_mem_drop", ifc.mem_valid, 32'd0);
      @(posedge clk);
      #1;
    end
    check("fork_mem_once", mem_hs - hs0, 32'd1);
    ifc.upd_ready = 1'b1;
    @(negedge clk);
    check("fork_release", ifc.input_ready, 32'd1);
    @(posedge clk);
    #1;
    ifc.input_valid = 1'b0;
    @(negedge clk);
    check("fork_next_mem", ifc.mem_valid, 32'd1);
    check("fork_next_upd", ifc.upd_valid, 32'd0);
    @(posedge clk);
    #1;

    // back-to-back stores, mem_ready toggling
    hs0 = mem_hs;
    begin
      int idx;
      int cyc;
      bit acc;
      ls_size_t sz;
      bit br;
      logic [31:0] s;
      idx = 0;
      cyc = 0;
      sz  = ls_size_t'($urandom_range(0, 2));
      br  = 1'($urandom_range(0, 1));
      s   = $urandom;
      mem_q.push_back(model(40, 5'd0, sz, 1'b1, br,
                            1'b0, 32'h4000, 32'h0, s));
      set_op(40, 5'd0, 5'd1, sz, 1'b1, br, 1'b0,
             1'b0, 32'h4000, 32'h0, s);
      while (idx < 8 && cyc < 100) begin
        @(negedge clk);
        acc = ifc.input_valid && ifc.input_ready;
        @(posedge clk);
        #1;
        cyc++;
        ifc.mem_ready = ~ifc.mem_ready;
        if (acc) begin
          idx++;
          if (idx < 8) begin
            sz = ls_size_t'($urandom_range(0, 2));
            br = 1'($urandom_range(0, 1));
            s  = $urandom;
            mem_q.push_back(model(40 + idx, 5'd0, sz, 1'b1,
                                  br, 1'b0, 32'h4000,
                                  idx * 4, s));
            set_op(40 + idx, 5'd0, 5'd1, sz, 1'b1, br,
                   1'b0, 1'b0, 32'h4000, idx * 4, s);
          end else begin
            ifc.input_valid = 1'b0;
          end
        end
      end
      check("b2b_accepted", idx, 32'd8);
    end
    ifc.input_valid = 1'b0;
    ifc.mem_ready   = 1'b1;
    for (int i = 0; i < 20 && mem_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    check("b2b_handshakes", mem_hs - hs0, 32'd8);
    check("mem_q_drained", mem_q.size(), 32'd0);
    check("upd_q_drained", upd_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
